gpio_input: RTL and testbench

GPIO_INPUT -- requirements
Module: gpio_input

---
 rtl/gpio_input.sv | 107 ++++++++++
 tb/tb_gpio_input.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/gpio_input.sv
// Debounced GPIO input block with STATE/EDGES/RAW read registers.
// Define GPIO_FALLING_EDGE_EN to also flag 1->0 debounced transitions.
module gpio_input #(
  parameter int          WIDTH           = 8,
  parameter int          DEBOUNCE_CYCLES = 4,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0100
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] pinsIn,
  input  logic [31:0]      address,
  input  logic             readEnable,
  input  logic             loadByte,
  output logic [31:0]      readData,
  output logic             dataValid,
  output logic             edgeIrq
);

  localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]      sync1_q, sync2_q;
  logic [WIDTH-1:0]      deb_q, deb_d;
  logic [WIDTH-1:0]      edges_q, edges_d;
  logic [WIDTH-1:0]      ev;
  logic [WIDTH-1:0][7:0] cnt_q, cnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [31:0]           sel;
  logic                  valid_q;
  logic                  irq_q;
  logic                  hit, accept, clr;
  logic                  unused_addr;

  assign unused_addr = ^address[1:0];

  assign hit    = (address[31:4] == BASE_ADDR[31:4]);
  assign accept = readEnable && hit;
  assign clr    = accept && (address[3:2] == 2'd1);

  // Counter reaching its last value on a mismatch commits the new level.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        cnt_d[i] = '0;
        deb_d[i] = sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

`ifdef GPIO_FALLING_EDGE_EN
  assign ev = deb_d ^ deb_q;
`else
  assign ev = deb_d & ~deb_q;
`endif

  // New events are OR-ed in after the clear so they survive a read.
  assign edges_d = (clr ? '0 : edges_q) | ev;

  always_comb begin
    sel = '0;
    case (address[3:2])
      2'd0:    sel = 32'(deb_q);
      2'd1:    sel = 32'(edges_q);
      2'd2:    sel = 32'(sync2_q);
      default: sel = '0;
    endcase
  end

  always_comb begin
    rdata_d = rdata_q;
    if (accept) begin
      rdata_d = loadByte ? {24'b0, sel[7:0]} : sel;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      cnt_q   <= '0;
      edges_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      sync1_q <= pinsIn;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      edges_q <= edges_d;
      rdata_q <= rdata_d;
      valid_q <= accept;
      irq_q   <= |edges_d;
    end
  end

  assign readData  = rdata_q;
  assign dataValid = valid_q;
  assign edgeIrq   = irq_q;

endmodule

// File: tb/tb_gpio_input.sv
// Directed testbench for gpio_input (WIDTH=8, DEBOUNCE_CYCLES=4, base 0x100).
// Honours GPIO_FALLING_EDGE_EN for falling-edge expectations.
module tb_gpio_input;

  logic        clock;
  logic        reset;
  logic [7:0]  pinsIn;
  logic [31:0] address;
  logic        readEnable;
  logic        loadByte;
  logic [31:0] readData;
  logic        dataValid;
  logic        edgeIrq;

  int checks = 0;
  int errors = 0;

  gpio_input #(
    .WIDTH(8),
    .DEBOUNCE_CYCLES(4),
    .BASE_ADDR(32'h0000_0100)
  ) dut (
    .clock(clock),
    .reset(reset),
    .pinsIn(pinsIn),
    .address(address),
    .readEnable(readEnable),
    .loadByte(loadByte),
    .readData(readData),
    .dataValid(dataValid),
    .edgeIrq(edgeIrq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Issue one read at the current negedge; check pulse and data next negedge.
  task automatic rd(input string tag, input logic [31:0] a,
                    input logic lb, input logic [31:0] exp);
    address    = a;
    loadByte   = lb;
    readEnable = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check({tag, "_dv"}, {31'b0, dataValid}, 32'd1);
    check(tag, readData, exp);
    readEnable = 1'b0;
    loadByte   = 1'b0;
  endtask

  logic [31:0] fall_exp;

  initial begin
    reset      = 1'b0;
    pinsIn     = 8'hFF;
    address    = 32'h0;
    readEnable = 1'b0;
    loadByte   = 1'b0;
    cyc(4);
    check("rst_rdata", readData, 32'h0);
    check("rst_dv", {31'b0, dataValid}, 32'd0);
    check("rst_irq", {31'b0, edgeIrq}, 32'd0);

    // Levels present at release need a full debounce from 0.
    reset = 1'b1;
    cyc(5);
    check("rel_irq5", {31'b0, edgeIrq}, 32'd0);
    cyc(1);
    check("rel_irq6", {31'b0, edgeIrq}, 32'd1);
    rd("rel_state", 32'h100, 1'b0, 32'hFF);
    rd("rel_edges", 32'h104, 1'b0, 32'hFF);
    check("rel_irq_clr", {31'b0, edgeIrq}, 32'd0);
    check("dv_pulse", {31'b0, dataValid}, 32'd1);
    cyc(1);
    check("dv_drop", {31'b0, dataValid}, 32'd0);

    // All pins fall.
    pinsIn = 8'h00;
    cyc(8);
    rd("fall_state", 32'h100, 1'b0, 32'h00);
`ifdef GPIO_FALLING_EDGE_EN
    fall_exp = 32'hFF;
`else
    fall_exp = 32'h00;
`endif
    rd("fall_edges", 32'h104, 1'b0, fall_exp);

    // Three-cycle glitch on bit0.
    pinsIn = 8'h01;
    cyc(2);
    address    = 32'h108;
    readEnable = 1'b1;
    @(negedge clock);
    pinsIn     = 8'h00;
    readEnable = 1'b0;
    check("glitch_raw", readData, 32'h01);
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      check("glitch_irq", {31'b0, edgeIrq}, 32'd0);
    end
    rd("glitch_state", 32'h100, 1'b0, 32'h00);
    rd("glitch_edges", 32'h104, 1'b0, 32'h00);
    rd("raw_zero", 32'h108, 1'b0, 32'h00);

    // Clean step to 0x81: exact latency, then back-to-back EDGES reads.
    pinsIn = 8'h81;
    cyc(5);
    check("step_irq5", {31'b0, edgeIrq}, 32'd0);
    cyc(1);
    check("step_irq6", {31'b0, edgeIrq}, 32'd1);
    cyc(4);
    rd("step_state", 32'h100, 1'b0, 32'h81);
    rd("step_edges1", 32'h104, 1'b0, 32'h81);
    rd("step_edges2", 32'h104, 1'b0, 32'h00);
    check("step_irq_clr", {31'b0, edgeIrq}, 32'd0);

    // Bit1 debounces on the same edge as an EDGES read.
    pinsIn = 8'h85;
    cyc(8);
    pinsIn = 8'h87;
    repeat (5) @(posedge clock);
    @(negedge clock);
    rd("coll_read", 32'h104, 1'b0, 32'h04);
    check("coll_irq", {31'b0, edgeIrq}, 32'd1);
    rd("coll_after", 32'h104, 1'b0, 32'h02);
    check("coll_irq_clr", {31'b0, edgeIrq}, 32'd0);

    // 0x87 -> 0xA5: bit5 rises, bit1 falls.
    pinsIn = 8'hA5;
    cyc(8);
    rd("a5_state", 32'h100, 1'b0, 32'hA5);
    address    = 32'h204;
    readEnable = 1'b1;
    @(negedge clock);
    readEnable = 1'b0;
    check("miss_dv", {31'b0, dataValid}, 32'd0);
    check("miss_rdata", readData, 32'hA5);
    check("miss_irq", {31'b0, edgeIrq}, 32'd1);
    rd("lb_state", 32'h101, 1'b1, 32'h0000_00A5);
    rd("reg3", 32'h10C, 1'b0, 32'h0);
`ifdef GPIO_FALLING_EDGE_EN
    fall_exp = 32'h22;
`else
    fall_exp = 32'h20;
`endif
    rd("lb_edges", 32'h106, 1'b1, fall_exp);
    check("lb_edges_irq", {31'b0, edgeIrq}, 32'd0);

    // Reset mid-debounce with a read in flight.
    pinsIn = 8'h00;
    cyc(3);
    address    = 32'h100;
    readEnable = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_rdata", readData, 32'h0);
    check("mid_rst_dv", {31'b0, dataValid}, 32'd0);
    check("mid_rst_irq", {31'b0, edgeIrq}, 32'd0);
    @(negedge clock);
    readEnable = 1'b0;
    reset = 1'b1;
    cyc(8);
    rd("mid_rst_state", 32'h100, 1'b0, 32'h00);
    rd("mid_rst_edges", 32'h104, 1'b0, 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
